// File: rtl/reg_writeback_sequencer_pkg.sv
// Shared widths, state encoding and constants for the write-back sequencer.
// No logic of its own: pure definitions, no latency.
// No flow control here; consumers apply their own handshakes.
package reg_writeback_sequencer_pkg;

   localparam int WORD       = 32;
   localparam int ADDR_WIDTH = 4;
   localparam int REG_COUNT  = 2 ** ADDR_WIDTH;

   // Register index of the program counter; writes here also raise pc_write.
   localparam logic [ADDR_WIDTH-1:0] PC_ADDR = ADDR_WIDTH'(REG_COUNT - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } seq_state_t;

endpackage

// File: rtl/reg_writeback_sequencer_reg_list_encoder.sv
// Lowest-set-bit priority encoder over a register list mask.
// Purely combinational, zero latency.
// No flow control; index is 0 when any_set is low.
module reg_list_encoder
   import reg_writeback_sequencer_pkg::*;
(
   input  logic [REG_COUNT-1:0]  mask,
   output logic [ADDR_WIDTH-1:0] index,
   output logic                  any_set
);

   // Scan from the top down so the lowest set bit is the last one to win.
   always_comb begin
      index   = '0;
      any_set = |mask;
      for (int i = REG_COUNT - 1; i >= 0; i--) begin
         if (mask[i]) begin
            index = ADDR_WIDTH'(i);
         end
      end
   end

endmodule

// File: rtl/reg_writeback_sequencer.sv
// Merges single write-backs and LDM/POP bursts into one register-file write port.
// One cycle from accepted request/beat to write_en; mem_ready is combinational.
// Single writes always win; a burst beat is held off (mem_ready low) that cycle.
module reg_writeback_sequencer
   import reg_writeback_sequencer_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  wb_valid_i,
   input  logic [ADDR_WIDTH-1:0] wb_addr_i,
   input  logic [WORD-1:0]       wb_data_i,
   input  logic                  burst_start_i,
   input  logic [REG_COUNT-1:0]  reg_list_i,
   input  logic                  mem_valid_i,
   input  logic [WORD-1:0]       mem_data_i,
   output logic                  mem_ready_o,
   output logic                  write_en_o,
   output logic [ADDR_WIDTH-1:0] write_addr_o,
   output logic [WORD-1:0]       write_data_o,
   output logic                  pc_write_o,
   output logic                  busy_o,
   output logic                  done_o
);

   seq_state_t            state_q, state_d;
   logic [REG_COUNT-1:0]  pending_q, pending_d;

   logic [ADDR_WIDTH-1:0] low_idx;
   logic                  pending_any;
   logic [REG_COUNT-1:0]  low_onehot;
   logic [REG_COUNT-1:0]  pending_cleared;
   logic [ADDR_WIDTH-1:0] rest_idx;
   logic                  rest_any;

   logic                  beat_acc;
   logic                  issue_en;
   logic [ADDR_WIDTH-1:0] issue_addr;
   logic [WORD-1:0]       issue_data;
   logic                  done_d;

   // Target of the next beat: lowest register still pending.
   reg_list_encoder u_low_enc (
      .mask    (pending_q),
      .index   (low_idx),
      .any_set (pending_any)
   );

   assign low_onehot      = {{(REG_COUNT-1){1'b0}}, 1'b1} << low_idx;
   assign pending_cleared = pending_q & ~low_onehot;

   // Whether anything remains once the current target is written; its index is
   // not needed, only the emptiness flag that marks the final beat.
   reg_list_encoder u_rest_enc (
      .mask    (pending_cleared),
      .index   (rest_idx),
      .any_set (rest_any)
   );

   // State and pending-mask register; reset abandons any burst in flight.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= IDLE;
         pending_q <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
      end
   end

   // Next-state, beat handshake and selection of the single write issued this cycle.
   always_comb begin
      state_d    = state_q;
      pending_d  = pending_q;
      done_d     = 1'b0;
      issue_en   = 1'b0;
      issue_addr = write_addr_o;
      issue_data = write_data_o;

      mem_ready_o = (state_q == BURST) && !wb_valid_i && pending_any;
      beat_acc    = mem_valid_i && mem_ready_o;

      case (state_q)
         IDLE: begin
            if (burst_start_i) begin
               if (|reg_list_i) begin
                  pending_d = reg_list_i;
                  state_d   = BURST;
               end else begin
                  // Empty list retires immediately with no writes.
                  done_d = 1'b1;
               end
            end
         end
         BURST: begin
            if (beat_acc) begin
               pending_d = pending_cleared;
               if (!rest_any) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d   = IDLE;
            pending_d = '0;
         end
      endcase

      if (wb_valid_i) begin
         issue_en   = 1'b1;
         issue_addr = wb_addr_i;
         issue_data = wb_data_i;
      end else if (beat_acc) begin
         issue_en   = 1'b1;
         issue_addr = low_idx;
         issue_data = mem_data_i;
      end
   end

   // Registered write port and status; address/data hold when no write issues.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         write_en_o   <= 1'b0;
         write_addr_o <= '0;
         write_data_o <= '0;
         pc_write_o   <= 1'b0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
      end else begin
         write_en_o   <= issue_en;
         write_addr_o <= issue_addr;
         write_data_o <= issue_data;
         pc_write_o   <= issue_en && (issue_addr == PC_ADDR);
         busy_o       <= (state_d == BURST);
         done_o       <= done_d;
      end
   end

endmodule

// File: tb/tb_reg_writeback_sequencer.sv
module tb_reg_writeback_sequencer;
   import reg_writeback_sequencer_pkg::*;

   logic                  clk;
   logic                  rst_n;
   logic                  wb_valid;
   logic [ADDR_WIDTH-1:0] wb_addr;
   logic [WORD-1:0]       wb_data;
   logic                  burst_start;
   logic [REG_COUNT-1:0]  reg_list;
   logic                  mem_valid;
   logic [WORD-1:0]       mem_data;
   logic                  mem_ready;
   logic                  write_en;
   logic [ADDR_WIDTH-1:0] write_addr;
   logic [WORD-1:0]       write_data;
   logic                  pc_write;
   logic                  busy;
   logic                  done;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      string       name;
      logic        wv;
      logic [3:0]  wa;
      logic [31:0] wd;
      logic        st;
      logic [15:0] rl;
      logic        mv;
      logic [31:0] md;
      logic        rdy;   // expected mem_ready in the drive cycle
      logic        ew;    // expected outputs one cycle later
      logic [3:0]  ea;
      logic [31:0] ed;
      logic        ep;
      logic        eb;
      logic        edn;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];

   reg_writeback_sequencer dut (
      .clk_i         (clk),
      .rst_n_i       (rst_n),
      .wb_valid_i    (wb_valid),
      .wb_addr_i     (wb_addr),
      .wb_data_i     (wb_data),
      .burst_start_i (burst_start),
      .reg_list_i    (reg_list),
      .mem_valid_i   (mem_valid),
      .mem_data_i    (mem_data),
      .mem_ready_o   (mem_ready),
      .write_en_o    (write_en),
      .write_addr_o  (write_addr),
      .write_data_o  (write_data),
      .pc_write_o    (pc_write),
      .busy_o        (busy),
      .done_o        (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   function automatic vec_t mk(input string name,
                               input logic wv, input logic [3:0] wa, input logic [31:0] wd,
                               input logic st, input logic [15:0] rl,
                               input logic mv, input logic [31:0] md,
                               input logic rdy, input logic ew, input logic [3:0] ea,
                               input logic [31:0] ed, input logic ep, input logic eb,
                               input logic edn);
      vec_t v;
      v.name = name; v.wv = wv; v.wa = wa; v.wd = wd; v.st = st; v.rl = rl;
      v.mv = mv; v.md = md; v.rdy = rdy; v.ew = ew; v.ea = ea; v.ed = ed;
      v.ep = ep; v.eb = eb; v.edn = edn;
      return v;
   endfunction

   // Drive one cycle, check mem_ready before the edge, queue the expectation
   // and score the registered outputs just after the edge.
   task automatic step(input vec_t v);
      vec_t e;
      @(negedge clk);
      wb_valid    = v.wv;
      wb_addr     = v.wa;
      wb_data     = v.wd;
      burst_start = v.st;
      reg_list    = v.rl;
      mem_valid   = v.mv;
      mem_data    = v.md;
      #1;
      chk({v.name, ".mem_ready"}, 32'(mem_ready), 32'(v.rdy));
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         compared++;
         mismatched++;
         $display("FAIL %s: scoreboard empty, got write_en %b, expected an entry", v.name, write_en);
      end else begin
         e = exp_q.pop_front();
         chk({e.name, ".write_en"}, 32'(write_en), 32'(e.ew));
         if (e.ew) begin
            chk({e.name, ".write_addr"}, 32'(write_addr), 32'(e.ea));
            chk({e.name, ".write_data"}, write_data, e.ed);
         end
         chk({e.name, ".pc_write"}, 32'(pc_write), 32'(e.ep));
         chk({e.name, ".busy"}, 32'(busy), 32'(e.eb));
         chk({e.name, ".done"}, 32'(done), 32'(e.edn));
      end
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, ".mem_ready"}, 32'(mem_ready), 32'd0);
      chk({name, ".write_en"}, 32'(write_en), 32'd0);
      chk({name, ".write_addr"}, 32'(write_addr), 32'd0);
      chk({name, ".write_data"}, write_data, 32'd0);
      chk({name, ".pc_write"}, 32'(pc_write), 32'd0);
      chk({name, ".busy"}, 32'(busy), 32'd0);
      chk({name, ".done"}, 32'(done), 32'd0);
   endtask

   initial begin
      rst_n       = 1'b0;
      wb_valid    = 1'b0;
      wb_addr     = '0;
      wb_data     = '0;
      burst_start = 1'b0;
      reg_list    = '0;
      mem_valid   = 1'b0;
      mem_data    = '0;

      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      //        name        wv wa     wd            st rl        mv md      rdy ew ea     ed            ep eb edn
      tbl.push_back(mk("single_r3", 1, 4'd3, 32'hDEADBEEF, 0, 16'h0000, 0, 32'h0, 0, 1, 4'd3, 32'hDEADBEEF, 0, 0, 0));
      tbl.push_back(mk("idle_a",    0, 4'd0, 32'h0,        0, 16'h0000, 0, 32'h0, 0, 0, 4'd0, 32'h0,        0, 0, 0));
      tbl.push_back(mk("single_pc", 1, 4'd15,32'h00001234, 0, 16'h0000, 0, 32'h0, 0, 1, 4'd15,32'h00001234, 1, 0, 0));
      // Burst 0x8011: r0, r4, r15 back to back.
      tbl.push_back(mk("b8011_st",  0, 4'd0, 32'h0,        1, 16'h8011, 0, 32'h0, 0, 0, 4'd0, 32'h0,        0, 1, 0));
      tbl.push_back(mk("b8011_r0",  0, 4'd0, 32'h0,        0, 16'h0000, 1, 32'hA, 1, 1, 4'd0, 32'hA,        0, 1, 0));
      tbl.push_back(mk("b8011_r4",  0, 4'd0, 32'h0,        0, 16'h0000, 1, 32'hB, 1, 1, 4'd4, 32'hB,        0, 1, 0));
      tbl.push_back(mk("b8011_r15", 0, 4'd0, 32'h0,        0, 16'h0000, 1, 32'hC, 1, 1, 4'd15,32'hC,        1, 0, 1));
      tbl.push_back(mk("idle_beat", 0, 4'd0, 32'h0,        0, 16'h0000, 1, 32'hFF,0, 0, 4'd0, 32'h0,        0, 0, 0));
      // Burst 0x0006 with a single write colliding with the second beat.
      tbl.push_back(mk("b0006_st",  0, 4'd0, 32'h0,        1, 16'h0006, 0, 32'h0, 0, 0, 4'd0, 32'h0,        0, 1, 0));
      tbl.push_back(mk("b0006_r1",  0, 4'd0, 32'h0,        0, 16'h0000, 1, 32'h11,1, 1, 4'd1, 32'h11,       0, 1, 0));
      tbl.push_back(mk("b0006_wb7", 1, 4'd7, 32'h55,       0, 16'h0000, 1, 32'h22,0, 1, 4'd7, 32'h55,       0, 1, 0));
      tbl.push_back(mk("b0006_r2",  0, 4'd0, 32'h0,        0, 16'h0000, 1, 32'h22,1, 1, 4'd2, 32'h22,       0, 0, 1));
      // Empty register list: no write, no busy, done one cycle later.
      tbl.push_back(mk("empty_st",  0, 4'd0, 32'h0,        1, 16'h0000, 0, 32'h0, 0, 0, 4'd0, 32'h0,        0, 0, 1));
      tbl.push_back(mk("empty_end", 0, 4'd0, 32'h0,        0, 16'h0000, 0, 32'h0, 0, 0, 4'd0, 32'h0,        0, 0, 0));
      // Start during a burst is ignored; a stall cycle in the middle.
      tbl.push_back(mk("b0300_st",  0, 4'd0, 32'h0,        1, 16'h0300, 0, 32'h0, 0, 0, 4'd0, 32'h0,        0, 1, 0));
      tbl.push_back(mk("b0300_r8",  0, 4'd0, 32'h0,        0, 16'h0000, 1, 32'h81,1, 1, 4'd8, 32'h81,       0, 1, 0));
      tbl.push_back(mk("b0300_stl", 0, 4'd0, 32'h0,        0, 16'h0000, 0, 32'h0, 1, 0, 4'd0, 32'h0,        0, 1, 0));
      tbl.push_back(mk("b0300_r9",  0, 4'd0, 32'h0,        1, 16'h0003, 1, 32'h82,1, 1, 4'd9, 32'h82,       0, 0, 1));
      tbl.push_back(mk("b0300_aft", 0, 4'd0, 32'h0,        0, 16'h0000, 1, 32'h83,0, 0, 4'd0, 32'h0,        0, 0, 0));
      // Start and single write together in IDLE.
      tbl.push_back(mk("b0020_wb6", 1, 4'd6, 32'h66,       1, 16'h0020, 0, 32'h0, 0, 1, 4'd6, 32'h66,       0, 1, 0));
      tbl.push_back(mk("b0020_r5",  0, 4'd0, 32'h0,        0, 16'h0000, 1, 32'h77,1, 1, 4'd5, 32'h77,       0, 0, 1));
      tbl.push_back(mk("idle_b",    0, 4'd0, 32'h0,        0, 16'h0000, 0, 32'h0, 0, 0, 4'd0, 32'h0,        0, 0, 0));

      foreach (tbl[i]) begin
         step(tbl[i]);
      end

      // Reset in the middle of burst 0x00F0 after its first beat.
      step(mk("bF0_st", 0, 4'd0, 32'h0, 1, 16'h00F0, 0, 32'h0,   0, 0, 4'd0, 32'h0,   0, 1, 0));
      step(mk("bF0_r4", 0, 4'd0, 32'h0, 0, 16'h0000, 1, 32'h100, 1, 1, 4'd4, 32'h100, 0, 1, 0));
      @(negedge clk);
      mem_valid = 1'b1;
      mem_data  = 32'h200;
      rst_n     = 1'b0;
      #1;
      chk_all_zero("midburst_rst");
      @(posedge clk);
      #1;
      chk_all_zero("midburst_rst_hold");
      @(negedge clk);
      rst_n = 1'b1;
      step(mk("post_rst_beat", 0, 4'd0, 32'h0, 0, 16'h0000, 1, 32'h200, 0, 0, 4'd0, 32'h0, 0, 0, 0));
      step(mk("post_rst_idle", 0, 4'd0, 32'h0, 0, 16'h0000, 1, 32'h201, 0, 0, 4'd0, 32'h0, 0, 0, 0));

      if (exp_q.size() != 0) begin
         compared++;
         mismatched++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
